// File: rtl/mips_decode_execute_unit_if.sv
// rtl/mips_decode_execute_unit_if.sv - decode/execute slice signal bundle
interface mips_decode_execute_unit_if;
    logic [31:0] Instruction;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [4:0]  WriteReg;
    logic [31:0] StoreData;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic [1:0]  MemType;

    // Upstream side: supplies the instruction and operands, observes the results
    modport master (
        output Instruction, ReadData1, ReadData2,
        input  ALUResult, Zero, WriteReg, StoreData,
        input  RegWrite, MemRead, MemWrite, MemToReg, MemType
    );

    // Decode/execute unit side
    modport slave (
        input  Instruction, ReadData1, ReadData2,
        output ALUResult, Zero, WriteReg, StoreData,
        output RegWrite, MemRead, MemWrite, MemToReg, MemType
    );
endinterface

// File: rtl/mips_decode_execute_unit.sv
// rtl/mips_decode_execute_unit.sv - MIPS decode + ALU stage with registered outputs
module mips_decode_execute_unit (
    input  logic                          Clk,
    input  logic                          Reset,
    mips_decode_execute_unit_if.slave     bus
);

    // ALUOp codes produced by the main controller
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_RTYPE = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_LUI   = 4'b0110;
    localparam logic [3:0] OP_SUB   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_NONE  = 4'b1111;

    // ALUControl encodings
    localparam logic [3:0] AC_AND  = 4'b0000;
    localparam logic [3:0] AC_OR   = 4'b0001;
    localparam logic [3:0] AC_ADD  = 4'b0010;
    localparam logic [3:0] AC_XOR  = 4'b0011;
    localparam logic [3:0] AC_NOR  = 4'b0100;
    localparam logic [3:0] AC_SUB  = 4'b0101;
    localparam logic [3:0] AC_SLT  = 4'b0110;
    localparam logic [3:0] AC_SLL  = 4'b0111;
    localparam logic [3:0] AC_SRL  = 4'b1000;
    localparam logic [3:0] AC_SRA  = 4'b1001;
    localparam logic [3:0] AC_SLLV = 4'b1010;
    localparam logic [3:0] AC_SRLV = 4'b1011;
    localparam logic [3:0] AC_LUI  = 4'b1100;
    localparam logic [3:0] AC_SLTU = 4'b1101;
    localparam logic [3:0] AC_SRAV = 4'b1110;
    localparam logic [3:0] AC_ZERO = 4'b1111;

    // Immediate flavours
    typedef enum logic [1:0] {
        IMM_SIGN = 2'd0,
        IMM_ZERO = 2'd1,
        IMM_LUI  = 2'd2
    } imm_kind_t;

    logic [5:0]  w_op;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;

    assign w_op    = bus.Instruction[31:26];
    assign w_rt    = bus.Instruction[20:16];
    assign w_rd    = bus.Instruction[15:11];
    assign w_shamt = bus.Instruction[10:6];
    assign w_funct = bus.Instruction[5:0];
    assign w_imm   = bus.Instruction[15:0];

    logic      w_reg_dst;
    logic      w_alu_src;
    logic      w_mem_to_reg;
    logic      w_reg_write;
    logic      w_mem_read;
    logic      w_mem_write;
    logic [3:0] w_alu_op;
    imm_kind_t w_imm_kind;

    // Main controller: opcode to datapath controls
    always_comb begin
        w_reg_dst    = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_op     = OP_NONE;
        w_imm_kind   = IMM_SIGN;
        case (w_op)
            6'b000000: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = OP_RTYPE;
            end
            6'b100011, 6'b100001, 6'b100000: begin
                w_alu_src    = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_mem_read   = 1'b1;
                w_alu_op     = OP_ADD;
            end
            6'b101011, 6'b101001, 6'b101000: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_alu_op    = OP_ADD;
            end
            6'b001000, 6'b001001: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = OP_ADD;
            end
            6'b001100: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = OP_AND;
                w_imm_kind  = IMM_ZERO;
            end
            6'b001101: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = OP_OR;
                w_imm_kind  = IMM_ZERO;
            end
            6'b001110: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = OP_XOR;
                w_imm_kind  = IMM_ZERO;
            end
            6'b001010: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = OP_SLT;
            end
            6'b001011: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = OP_SLTU;
            end
            6'b001111: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = OP_LUI;
                w_imm_kind  = IMM_LUI;
            end
            6'b000100, 6'b000101: begin
                w_alu_op = OP_SUB;
            end
            default: begin
                w_alu_op = OP_NONE;
            end
        endcase
    end

    logic [31:0] w_imm_val;

    // Immediate selection: sign-extend by default, zero-extend for logical ops
    always_comb begin
        w_imm_val = {{16{w_imm[15]}}, w_imm};
        case (w_imm_kind)
            IMM_ZERO: w_imm_val = {16'h0000, w_imm};
            IMM_LUI:  w_imm_val = {w_imm, 16'h0000};
            default:  w_imm_val = {{16{w_imm[15]}}, w_imm};
        endcase
    end

    logic [3:0] w_alu_ctrl;

    // ALU controller: ALUOp plus funct to ALUControl
    always_comb begin
        w_alu_ctrl = AC_ZERO;
        case (w_alu_op)
            OP_ADD:  w_alu_ctrl = AC_ADD;
            OP_AND:  w_alu_ctrl = AC_AND;
            OP_OR:   w_alu_ctrl = AC_OR;
            OP_XOR:  w_alu_ctrl = AC_XOR;
            OP_SLT:  w_alu_ctrl = AC_SLT;
            OP_SLTU: w_alu_ctrl = AC_SLTU;
            OP_LUI:  w_alu_ctrl = AC_LUI;
            OP_SUB:  w_alu_ctrl = AC_SUB;
            OP_RTYPE: begin
                case (w_funct)
                    6'h20, 6'h21: w_alu_ctrl = AC_ADD;
                    6'h22, 6'h23: w_alu_ctrl = AC_SUB;
                    6'h24:        w_alu_ctrl = AC_AND;
                    6'h25:        w_alu_ctrl = AC_OR;
                    6'h26:        w_alu_ctrl = AC_XOR;
                    6'h27:        w_alu_ctrl = AC_NOR;
                    6'h2A:        w_alu_ctrl = AC_SLT;
                    6'h2B:        w_alu_ctrl = AC_SLTU;
                    6'h00:        w_alu_ctrl = AC_SLL;
                    6'h02:        w_alu_ctrl = AC_SRL;
                    6'h03:        w_alu_ctrl = AC_SRA;
                    6'h04:        w_alu_ctrl = AC_SLLV;
                    6'h06:        w_alu_ctrl = AC_SRLV;
                    6'h07:        w_alu_ctrl = AC_SRAV;
                    default:      w_alu_ctrl = AC_ZERO;
                endcase
            end
            default: w_alu_ctrl = AC_ZERO;
        endcase
    end

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [4:0]  w_vshamt;
    logic [31:0] w_result;

    assign w_a      = bus.ReadData1;
    assign w_b      = w_alu_src ? w_imm_val : bus.ReadData2;
    assign w_vshamt = bus.ReadData1[4:0];

    // ALU datapath; shifts always act on ReadData2
    always_comb begin
        w_result = 32'h0000_0000;
        case (w_alu_ctrl)
            AC_AND:  w_result = w_a & w_b;
            AC_OR:   w_result = w_a | w_b;
            AC_ADD:  w_result = w_a + w_b;
            AC_XOR:  w_result = w_a ^ w_b;
            AC_NOR:  w_result = ~(w_a | w_b);
            AC_SUB:  w_result = w_a - w_b;
            AC_SLT:  w_result = {31'd0, $signed(w_a) < $signed(w_b)};
            AC_SLTU: w_result = {31'd0, w_a < w_b};
            AC_SLL:  w_result = bus.ReadData2 << w_shamt;
            AC_SRL:  w_result = bus.ReadData2 >> w_shamt;
            AC_SRA:  w_result = $unsigned($signed(bus.ReadData2) >>> w_shamt);
            AC_SLLV: w_result = bus.ReadData2 << w_vshamt;
            AC_SRLV: w_result = bus.ReadData2 >> w_vshamt;
            AC_SRAV: w_result = $unsigned($signed(bus.ReadData2) >>> w_vshamt);
            AC_LUI:  w_result = w_b;
            default: w_result = 32'h0000_0000;
        endcase
    end

    logic [31:0] r_alu_result;
    logic        r_zero;
    logic [4:0]  r_write_reg;
    logic [31:0] r_store_data;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_mem_to_reg;
    logic [1:0]  r_mem_type;

    // Decode/execute pipeline register; reset wins over capture
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_alu_result <= 32'h0000_0000;
            r_zero       <= 1'b0;
            r_write_reg  <= 5'd0;
            r_store_data <= 32'h0000_0000;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_type   <= 2'b00;
        end else begin
            r_alu_result <= w_result;
            r_zero       <= (w_result == 32'h0000_0000);
            r_write_reg  <= w_reg_dst ? w_rd : w_rt;
            r_store_data <= bus.ReadData2;
            r_reg_write  <= w_reg_write;
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_mem_to_reg <= w_mem_to_reg;
            r_mem_type   <= bus.Instruction[27:26];
        end
    end

    assign bus.ALUResult = r_alu_result;
    assign bus.Zero      = r_zero;
    assign bus.WriteReg  = r_write_reg;
    assign bus.StoreData = r_store_data;
    assign bus.RegWrite  = r_reg_write;
    assign bus.MemRead   = r_mem_read;
    assign bus.MemWrite  = r_mem_write;
    assign bus.MemToReg  = r_mem_to_reg;
    assign bus.MemType   = r_mem_type;

endmodule

// File: tb/tb_mips_decode_execute_unit.sv
// tb/tb_mips_decode_execute_unit.sv - randomized model-checked bench for mips_decode_execute_unit
module tb_mips_decode_execute_unit;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mips_decode_execute_unit_if bus ();

    mips_decode_execute_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  wreg;
        logic [31:0] sd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mtr;
        logic [1:0]  mt;
    } exp_t;

    // Architectural meaning of each instruction, straight from the ISA rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] sx;
        logic [31:0] zx;
        op = ins[31:26];
        fn = ins[5:0];
        sh = ins[10:6];
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0, ins[15:0]};
        e = '0;
        e.wreg = ins[20:16];
        e.sd   = b;
        e.mt   = ins[27:26];
        case (op)
            6'h00: begin
                e.rw = 1'b1;
                e.wreg = ins[15:11];
                case (fn)
                    6'h20, 6'h21: e.res = a + b;
                    6'h22, 6'h23: e.res = a - b;
                    6'h24: e.res = a & b;
                    6'h25: e.res = a | b;
                    6'h26: e.res = a ^ b;
                    6'h27: e.res = ~(a | b);
                    6'h2A: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: e.res = (a < b) ? 32'd1 : 32'd0;
                    6'h00: e.res = b << sh;
                    6'h02: e.res = b >> sh;
                    6'h03: e.res = $unsigned($signed(b) >>> sh);
                    6'h04: e.res = b << a[4:0];
                    6'h06: e.res = b >> a[4:0];
                    6'h07: e.res = $unsigned($signed(b) >>> a[4:0]);
                    default: e.res = 32'd0;
                endcase
            end
            6'h23, 6'h21, 6'h20: begin
                e.res = a + sx; e.rw = 1'b1; e.mr = 1'b1; e.mtr = 1'b1;
            end
            6'h2B, 6'h29, 6'h28: begin
                e.res = a + sx; e.mw = 1'b1;
            end
            6'h08, 6'h09: begin e.res = a + sx; e.rw = 1'b1; end
            6'h0C: begin e.res = a & zx; e.rw = 1'b1; end
            6'h0D: begin e.res = a | zx; e.rw = 1'b1; end
            6'h0E: begin e.res = a ^ zx; e.rw = 1'b1; end
            6'h0A: begin e.res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; e.rw = 1'b1; end
            6'h0B: begin e.res = (a < sx) ? 32'd1 : 32'd0; e.rw = 1'b1; end
            6'h0F: begin e.res = {ins[15:0], 16'h0}; e.rw = 1'b1; end
            6'h04, 6'h05: e.res = a - b;
            default: e.res = 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    function automatic exp_t dut_now();
        exp_t g;
        g.res  = bus.ALUResult;
        g.zero = bus.Zero;
        g.wreg = bus.WriteReg;
        g.sd   = bus.StoreData;
        g.rw   = bus.RegWrite;
        g.mr   = bus.MemRead;
        g.mw   = bus.MemWrite;
        g.mtr  = bus.MemToReg;
        g.mt   = bus.MemType;
        return g;
    endfunction

    exp_t exp_cur;
    bit   have_exp = 1'b0;
    int   cyc = 0;

    // Predict the register contents captured at each rising edge
    always @(posedge Clk) begin
        exp_cur  = Reset ? exp_t'('0) : model(bus.Instruction, bus.ReadData1, bus.ReadData2);
        have_exp = 1'b1;
        cyc++;
    end

    // Check every output on the falling edge against the prediction
    always @(negedge Clk) begin
        if (have_exp) begin
            exp_t g;
            g = dut_now();
            total++;
            if (g !== exp_cur) begin
                bad++;
                $display("FAIL cycle%0d outputs: got %h exp %h", cyc, g, exp_cur);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %h exp %h", name, got, expv);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic rst);
        Reset           = rst;
        bus.Instruction = ins;
        bus.ReadData1   = a;
        bus.ReadData2   = b;
        @(posedge Clk);
        #2;
    endtask

    logic [5:0] ops [20] = '{6'h00, 6'h23, 6'h21, 6'h20, 6'h2B, 6'h29, 6'h28, 6'h08, 6'h09, 6'h0C,
                             6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F, 6'h04, 6'h05, 6'h00, 6'h3F, 6'h00};
    logic [5:0] fns [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

    initial begin
        bus.Instruction = 32'h0;
        bus.ReadData1   = 32'h0;
        bus.ReadData2   = 32'h0;

        step(32'h8C220004, 32'h100, 32'h55, 1'b1);
        step(32'h8C220004, 32'h100, 32'h55, 1'b1);
        check("rst_result", bus.ALUResult, 32'h0);
        check("rst_ctrl", {27'd0, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.MemToReg, bus.Zero}, 32'h0);
        check("rst_wreg_sd", {bus.WriteReg, bus.MemType, 25'd0} | bus.StoreData, 32'h0);

        step(32'h8C220004, 32'h100, 32'h55, 1'b0);
        check("lw_result", bus.ALUResult, 32'h104);
        check("lw_ctrl", {28'd0, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.MemToReg}, 32'hD);
        check("lw_wreg", {27'd0, bus.WriteReg}, 32'd2);
        check("lw_mtype", {30'd0, bus.MemType}, 32'd3);
        check("lw_store", bus.StoreData, 32'h55);

        step(32'h00221820, 32'h7FFFFFFF, 32'h1, 1'b0);
        check("add_wrap", bus.ALUResult, 32'h80000000);
        check("add_wreg", {26'd0, bus.WriteReg, bus.RegWrite}, {26'd0, 5'd3, 1'b1});
        check("add_zero", {31'd0, bus.Zero}, 32'd0);

        step(32'h00221822, 32'h1234, 32'h1234, 1'b0);
        check("sub_eq", {bus.ALUResult[30:0], bus.Zero}, 32'd1);
        step(32'h10220003, 32'h55, 32'h55, 1'b0);
        check("beq_eq", {30'd0, bus.RegWrite, bus.Zero}, 32'd1);
        step(32'h00021903, 32'h0, 32'hF0000000, 1'b0);
        check("sra", bus.ALUResult, 32'hFF000000);
        step(32'h00021902, 32'h0, 32'hF0000000, 1'b0);
        check("srl", bus.ALUResult, 32'h0F000000);
        step(32'h0022182A, 32'hFFFFFFFF, 32'h1, 1'b0);
        check("slt", bus.ALUResult, 32'd1);
        step(32'h0022182B, 32'hFFFFFFFF, 32'h1, 1'b0);
        check("sltu", bus.ALUResult, 32'd0);
        step(32'h3022FFFF, 32'h12345678, 32'h0, 1'b0);
        check("andi", bus.ALUResult, 32'h00005678);
        step(32'h3C02ABCD, 32'h12345678, 32'h0, 1'b0);
        check("lui", bus.ALUResult, 32'hABCD0000);
        step(32'hFC000000, 32'h1, 32'h2, 1'b0);
        check("undef_ctrl", {28'd0, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.MemToReg}, 32'd0);
        check("undef_res", {bus.ALUResult[30:0], bus.Zero}, 32'd1);
        step(32'h00221820, 32'h5, 32'h6, 1'b1);
        check("midrst", bus.ALUResult, 32'd0);
        step(32'h00221820, 32'h5, 32'h6, 1'b0);
        check("post_rst", bus.ALUResult, 32'd11);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            logic [31:0] a;
            logic [31:0] b;
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 19)];
            if (ins[31:26] == 6'h00 && $urandom_range(0, 7) != 0)
                ins[5:0] = fns[$urandom_range(0, 15)];
            if ($urandom_range(0, 9) == 0)
                ins = $urandom;
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
            step(ins, a, b, ($urandom_range(0, 29) == 0));
        end

        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
